// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer controller: keypad entry into an MM:SS BCD register,
// per-second countdown from an internal prescaler, pause/resume and done beep.
module microwave_timer_ctrl #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int BEEP_SECS     = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    output logic       heating,
    output logic       beep,
    output logic       done,
    output logic [1:0] state,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones
);

    localparam int PW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BEEP_CYC = BEEP_SECS * TICKS_PER_SEC;
    localparam int BW       = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COOK   = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         st;
    logic [15:0]    tm;
    logic [PW-1:0]  presc;
    logic [BW-1:0]  beep_cnt;
    logic [15:0]    tm_dec;

    // One-second BCD decrement with ones/tens borrow; 00:00 stays 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, stn, so;
        {mt, mo, stn, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else if (stn != 4'd0) begin
            so  = 4'd9;
            stn = stn - 4'd1;
        end else if ({mt, mo} != 8'd0) begin
            so  = 4'd9;
            stn = 4'd5;
            if (mo != 4'd0) begin
                mo = mo - 4'd1;
            end else begin
                mo = 4'd9;
                mt = mt - 4'd1;
            end
        end
        return {mt, mo, stn, so};
    endfunction

    assign tm_dec   = bcd_dec(tm);
    assign heating  = (st == COOK) & door_closed;
    assign state    = st;
    assign min_tens = tm[15:12];
    assign min_ones = tm[11:8];
    assign sec_tens = tm[7:4];
    assign sec_ones = tm[3:0];

    always_ff @(posedge clk) begin
        if (clear) begin
            st       <= IDLE;
            tm       <= 16'h0000;
            presc    <= '0;
            beep_cnt <= '0;
            beep     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (stop) begin
                        tm <= 16'h0000;
                    end else if (start && door_closed && (tm != 16'h0000)) begin
                        st    <= COOK;
                        presc <= '0;
                    end else if (key_valid && (key_digit <= 4'd9)) begin
                        tm <= {tm[11:0], key_digit};
                    end
                end
                COOK: begin
                    if (stop || !door_closed) begin
                        st <= PAUSED;
                    end else if (presc == PRESC_LAST) begin
                        presc <= '0;
                        tm    <= tm_dec;
                        if (tm_dec == 16'h0000) begin
                            st       <= DONE;
                            done     <= 1'b1;
                            beep     <= 1'b1;
                            beep_cnt <= '0;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                PAUSED: begin
                    // Prescaler is left untouched so the partial second resumes.
                    if (stop) begin
                        st <= IDLE;
                        tm <= 16'h0000;
                    end else if (start && door_closed) begin
                        st <= COOK;
                    end
                end
                DONE: begin
                    if (stop || (beep_cnt == BEEP_LAST)) begin
                        st   <= IDLE;
                        beep <= 1'b0;
                    end else begin
                        beep_cnt <= beep_cnt + 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
